term_ctrl: RTL and testbench

Parametrised text-terminal controller between the serial receiver and the character VRAM. It accepts one byte per valid/ready handshake, interprets control codes, writes printable characters at the cursor with auto-margin, and drives VRAM write cycles. Screen geometry is set by parameters. Scrolling is done in hardware through a circular row-base register that the video scanner adds to its row index, so a scroll costs one blank-row fill instead of a full-screen copy.

---
 rtl/term_ctrl_if.sv | 10 +
 rtl/term_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_term_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_ctrl_if.sv
// Byte-stream handshake from the serial receiver into the terminal controller.
// A byte moves on a rising edge where i_valid and o_ready are both high.
interface term_ctrl_if;
   logic [7:0] i_char;
   logic       i_valid;
   logic       o_ready;

   modport master (output i_char, output i_valid, input o_ready);
   modport slave  (input i_char, input i_valid, output o_ready);
endinterface

// File: rtl/term_ctrl.sv
// Text-terminal controller: interprets received bytes, writes characters at the
// cursor and scrolls by rotating a circular row base instead of copying VRAM.
module term_ctrl #(
   parameter int         COLS  = 60,
   parameter int         ROWS  = 17,
   parameter int         COL_W = 6,
   parameter int         ROW_W = 5,
   parameter int         TAB   = 8,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   term_ctrl_if.slave             rx,
   output logic [ROW_W+COL_W-1:0] o_vram_addr,
   output logic [7:0]             o_vram_din,
   output logic                   o_vram_we,
   output logic                   o_vram_ce,
   output logic [ROW_W-1:0]       o_row_base,
   output logic [ROW_W-1:0]       o_cur_row,
   output logic [COL_W-1:0]       o_cur_col,
   output logic                   o_bel
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ROW,
      S_WAIT_COL,
      S_WRITE,
      S_FILL
   } state_t;

   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] TAB_MASK = ~COL_W'(TAB - 1);
   localparam logic [COL_W:0]   TAB_STEP = (COL_W+1)'(TAB);
   localparam logic [ROW_W:0]   ROWS_W   = (ROW_W+1)'(ROWS);
   localparam logic [7:0]       ROW_LIM  = 8'(ROWS - 1);
   localparam logic [7:0]       COL_LIM  = 8'(COLS - 1);

   state_t           state,    state_nx;
   logic [ROW_W-1:0] row,      row_nx;
   logic [COL_W-1:0] col,      col_nx;
   logic [ROW_W-1:0] row_base, row_base_nx;
   logic [7:0]       ch,       ch_nx;
   logic [ROW_W-1:0] frow,     frow_nx;
   logic [ROW_W-1:0] fend,     fend_nx;
   logic [COL_W-1:0] fcol,     fcol_nx;
   logic             bel,      bel_nx;

   logic             ready;
   logic             accept;
   logic             start_scroll;
   logic [ROW_W:0]   prow_sum;
   logic [ROW_W-1:0] prow;
   logic [COL_W:0]   tab_sum;
   logic [COL_W-1:0] tab_col;
   logic [7:0]       pos_v;

   // Logical-to-physical row mapping through the circular row base.
   always_comb begin
      prow_sum = {1'b0, row_base} + {1'b0, row};
      prow     = ROW_W'((prow_sum >= ROWS_W) ? (prow_sum - ROWS_W) : prow_sum);
   end

   always_comb begin
      tab_sum = {1'b0, col & TAB_MASK} + TAB_STEP;
      tab_col = (tab_sum > {1'b0, COL_MAX}) ? COL_MAX : COL_W'(tab_sum);
      pos_v   = rx.i_char - 8'h20;
   end

   assign ready     = !i_rst && (state == S_IDLE || state == S_WAIT_ROW || state == S_WAIT_COL);
   assign rx.o_ready = ready;
   assign accept    = rx.i_valid && ready;

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned; a missing default here would infer a latch.
   always_comb begin
      state_nx     = state;
      row_nx       = row;
      col_nx       = col;
      row_base_nx  = row_base;
      ch_nx        = ch;
      frow_nx      = frow;
      fend_nx      = fend;
      fcol_nx      = fcol;
      bel_nx       = 1'b0;
      start_scroll = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (accept) begin
               case (rx.i_char)
                  8'h00: ;
                  8'h07: bel_nx = 1'b1;
                  8'h08, 8'h7F: begin
                     if (col != '0) col_nx = col - 1'b1;
                  end
                  8'h0D: col_nx = '0;
                  8'h09: col_nx = tab_col;
                  8'h0A: begin
                     if (row != ROW_MAX) row_nx = row + 1'b1;
                     else                start_scroll = 1'b1;
                  end
                  8'h0C: begin
                     row_nx      = '0;
                     col_nx      = '0;
                     row_base_nx = '0;
                     frow_nx     = '0;
                     fend_nx     = ROW_MAX;
                     fcol_nx     = '0;
                     state_nx    = S_FILL;
                  end
                  8'h0B: begin
                     frow_nx  = prow;
                     fend_nx  = prow;
                     fcol_nx  = col;
                     state_nx = S_FILL;
                  end
                  8'h14: state_nx = S_WAIT_ROW;
                  default: begin
                     ch_nx    = rx.i_char;
                     state_nx = S_WRITE;
                  end
               endcase
            end
         end

         // Cursor-address bytes carry a 20h bias; underflow clamps to the edge.
         S_WAIT_ROW: begin
            if (accept) begin
               row_nx   = (pos_v > ROW_LIM) ? ROW_MAX : ROW_W'(pos_v);
               state_nx = S_WAIT_COL;
            end
         end

         S_WAIT_COL: begin
            if (accept) begin
               col_nx   = (pos_v > COL_LIM) ? COL_MAX : COL_W'(pos_v);
               state_nx = S_IDLE;
            end
         end

         S_WRITE: begin
            if (col != COL_MAX) begin
               col_nx   = col + 1'b1;
               state_nx = S_IDLE;
            end else begin
               col_nx = '0;
               if (row != ROW_MAX) begin
                  row_nx   = row + 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  start_scroll = 1'b1;
               end
            end
         end

         S_FILL: begin
            if (fcol != COL_MAX) begin
               fcol_nx = fcol + 1'b1;
            end else begin
               fcol_nx = '0;
               if (frow == fend) state_nx = S_IDLE;
               else              frow_nx  = frow + 1'b1;
            end
         end

         default: state_nx = S_IDLE;
      endcase

      // Scroll: blank the old top row, which becomes the new bottom row.
      if (start_scroll) begin
         frow_nx     = row_base;
         fend_nx     = row_base;
         fcol_nx     = '0;
         row_base_nx = (row_base == ROW_MAX) ? '0 : row_base + 1'b1;
         row_nx      = ROW_MAX;
         state_nx    = S_FILL;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_IDLE;
         row      <= '0;
         col      <= '0;
         row_base <= '0;
         ch       <= '0;
         frow     <= '0;
         fend     <= '0;
         fcol     <= '0;
         bel      <= 1'b0;
      end else begin
         state    <= state_nx;
         row      <= row_nx;
         col      <= col_nx;
         row_base <= row_base_nx;
         ch       <= ch_nx;
         frow     <= frow_nx;
         fend     <= fend_nx;
         fcol     <= fcol_nx;
         bel      <= bel_nx;
      end
   end

   always_comb begin
      o_vram_we = (state == S_WRITE) || (state == S_FILL);
      o_vram_ce = o_vram_we;
      if (state == S_FILL) begin
         o_vram_addr = {frow, fcol};
         o_vram_din  = BLANK;
      end else begin
         o_vram_addr = {prow, col};
         o_vram_din  = ch;
      end
   end

   assign o_row_base = row_base;
   assign o_cur_row  = row;
   assign o_cur_col  = col;
   assign o_bel      = bel;

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: expected VRAM writes are queued as bytes
// are sent and popped by a monitor that samples the write port on the falling edge.
module tb_term_ctrl;
   localparam int COLS  = 60;
   localparam int ROWS  = 17;
   localparam int COL_W = 6;
   localparam int ROW_W = 5;
   localparam int AW    = ROW_W + COL_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [AW-1:0]    vaddr;
   logic [7:0]       vdin;
   logic             we, ce, bel;
   logic [ROW_W-1:0] row_base, cur_row;
   logic [COL_W-1:0] cur_col;

   term_ctrl_if bus();

   term_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .TAB(8), .BLANK(8'h20)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .rx         (bus),
      .o_vram_addr(vaddr),
      .o_vram_din (vdin),
      .o_vram_we  (we),
      .o_vram_ce  (ce),
      .o_row_base (row_base),
      .o_cur_row  (cur_row),
      .o_cur_col  (cur_col),
      .o_bel      (bel)
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_total  = 0;
   int n_writes = 0;
   logic [AW+7:0] exp_q[$];

   function automatic logic [AW+7:0] wr(input int prow, input int col, input logic [7:0] d);
      return {ROW_W'(prow), COL_W'(col), d};
   endfunction

   // Scoreboard consumer: every write strobe must match the next queued write.
   always @(negedge clk) begin
      logic [AW+7:0] e;
      if (!rst && we) begin
         n_writes++;
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL vram_write_unexpected: got addr=%h din=%h, required no write", vaddr, vdin);
         end else begin
            e = exp_q.pop_front();
            if ({vaddr, vdin} !== e || ce !== 1'b1)
               $display("FAIL vram_write: got addr=%h din=%h ce=%b, required addr=%h din=%h ce=1",
                        vaddr, vdin, ce, e[AW+7:8], e[7:0]);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called on a falling edge; returns on the falling edge after the accept edge.
   task automatic send(input logic [7:0] b, output int stall);
      stall = 0;
      bus.i_char  = b;
      bus.i_valid = 1'b1;
      while (bus.o_ready !== 1'b1 && stall < 3000) begin
         @(negedge clk);
         stall++;
      end
      if (bus.o_ready !== 1'b1) begin
         n_total++;
         $display("FAIL send_timeout: byte %h ready=%b, required 1", b, bus.o_ready);
      end
      @(posedge clk);
      #1 bus.i_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send1(input logic [7:0] b);
      int s;
      send(b, s);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.o_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (bus.o_ready !== 1'b1) $display("FAIL wait_idle_timeout: ready=%b, required 1", bus.o_ready);
      else if (exp_q.size() != 0) $display("FAIL writes_missing: got %0d pending, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic goto_rc(input int r, input int c);
      send1(8'h14);
      send1(8'(r + 32));
      send1(8'(c + 32));
   endtask

   task automatic push_row_fill(input int prow, input int c0);
      for (int c = c0; c < COLS; c++) exp_q.push_back(wr(prow, c, 8'h20));
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b0;
      bus.i_char  = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if (bus.o_ready !== 1'b0) $display("FAIL reset_ready_low: got %b required 0", bus.o_ready);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.o_ready, we, ce, bel, row_base, cur_row, cur_col} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 6'd0})
         $display("FAIL reset_state: got ready=%b we=%b ce=%b bel=%b base=%0d row=%0d col=%0d required 1 0 0 0 0 0 0",
                  bus.o_ready, we, ce, bel, row_base, cur_row, cur_col);
      else n_pass++;
   endtask

   task automatic test_char();
      int s;
      exp_q.push_back(wr(0, 0, 8'h41));
      send1(8'h41);
      send(8'h00, s);
      n_total++;
      if (s !== 1) $display("FAIL char_busy_cycles: got %0d required 1", s);
      else n_pass++;
      n_total++;
      if (cur_row !== 5'd0 || cur_col !== 6'd1)
         $display("FAIL char_cursor: got (%0d,%0d) required (0,1)", cur_row, cur_col);
      else n_pass++;
   endtask

   task automatic test_goto();
      send1(8'h14); send1(8'h22); send1(8'h7F);
      n_total++;
      if (cur_row !== 5'd2 || cur_col !== 6'd59)
         $display("FAIL goto_clamp_col: got (%0d,%0d) required (2,59)", cur_row, cur_col);
      else n_pass++;
      send1(8'h14); send1(8'h05); send1(8'h30);
      n_total++;
      if (cur_row !== 5'd16 || cur_col !== 6'd16)
         $display("FAIL goto_underflow_row: got (%0d,%0d) required (16,16)", cur_row, cur_col);
      else n_pass++;
   endtask

   task automatic test_wrap_scroll();
      int w0;
      goto_rc(ROWS - 1, COLS - 1);
      w0 = n_writes;
      exp_q.push_back(wr(16, 59, 8'h5A));
      push_row_fill(0, 0);
      send1(8'h5A);
      wait_idle();
      n_total++;
      if (row_base !== 5'd1 || cur_row !== 5'd16 || cur_col !== 6'd0 || n_writes - w0 !== 61)
         $display("FAIL wrap_scroll: got base=%0d cur=(%0d,%0d) writes=%0d required base=1 cur=(16,0) writes=61",
                  row_base, cur_row, cur_col, n_writes - w0);
      else n_pass++;
   endtask

   task automatic test_lf_scroll();
      for (int r = 0; r < ROWS; r++) push_row_fill(r, 0);
      send1(8'h0C);
      wait_idle();
      for (int i = 0; i < ROWS - 1; i++) send1(8'h0A);
      n_total++;
      if (cur_row !== 5'd16 || row_base !== 5'd0)
         $display("FAIL lf_no_scroll: got row=%0d base=%0d required row=16 base=0", cur_row, row_base);
      else n_pass++;
      push_row_fill(0, 0);
      send1(8'h0A);
      wait_idle();
      n_total++;
      if (row_base !== 5'd1 || cur_row !== 5'd16)
         $display("FAIL lf_first_scroll: got base=%0d row=%0d required base=1 row=16", row_base, cur_row);
      else n_pass++;
      for (int b = 1; b < ROWS; b++) begin
         push_row_fill(b, 0);
         send1(8'h0A);
         wait_idle();
      end
      n_total++;
      if (row_base !== 5'd0) $display("FAIL lf_base_wrap: got base=%0d required 0", row_base);
      else n_pass++;
      for (int b = 0; b < 5; b++) begin
         push_row_fill(b, 0);
         send1(8'h0A);
         wait_idle();
      end
      n_total++;
      if (row_base !== 5'd5) $display("FAIL lf_base5: got base=%0d required 5", row_base);
      else n_pass++;
      // Logical row 16 with base 5 maps to physical row (5+16)-17 = 4.
      exp_q.push_back(wr(4, 0, 8'h51));
      send1(8'h51);
      wait_idle();
   endtask

   task automatic test_ff();
      int s;
      for (int r = 0; r < ROWS; r++) push_row_fill(r, 0);
      send1(8'h0C);
      send(8'h00, s);
      n_total++;
      if (s !== ROWS * COLS) $display("FAIL ff_stall: got %0d cycles required %0d", s, ROWS * COLS);
      else n_pass++;
      n_total++;
      if (row_base !== 5'd0 || cur_row !== 5'd0 || cur_col !== 6'd0 || exp_q.size() != 0)
         $display("FAIL ff_state: got base=%0d cur=(%0d,%0d) pending=%0d required 0 (0,0) 0",
                  row_base, cur_row, cur_col, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_ht();
      goto_rc(0, 57);
      send1(8'h09);
      n_total++;
      if (cur_col !== 6'd59) $display("FAIL ht_clamp: got %0d required 59", cur_col);
      else n_pass++;
      goto_rc(0, 3);
      send1(8'h09);
      n_total++;
      if (cur_col !== 6'd8) $display("FAIL ht_stop: got %0d required 8", cur_col);
      else n_pass++;
   endtask

   task automatic test_vt();
      int w0;
      goto_rc(3, 50);
      w0 = n_writes;
      push_row_fill(3, 50);
      send1(8'h0B);
      wait_idle();
      n_total++;
      if (n_writes - w0 !== 10 || cur_row !== 5'd3 || cur_col !== 6'd50)
         $display("FAIL vt_erase: got writes=%0d cur=(%0d,%0d) required writes=10 cur=(3,50)",
                  n_writes - w0, cur_row, cur_col);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int s1, s2, s3;
      send(8'h08, s1);
      send(8'h7F, s2);
      send(8'h0D, s3);
      n_total++;
      if (s1 + s2 + s3 !== 0 || cur_col !== 6'd0)
         $display("FAIL back_to_back: got stalls=%0d col=%0d required stalls=0 col=0", s1 + s2 + s3, cur_col);
      else n_pass++;
      send1(8'h08);
      n_total++;
      if (cur_col !== 6'd0) $display("FAIL bs_at_zero: got %0d required 0", cur_col);
      else n_pass++;
   endtask

   task automatic test_bel();
      send1(8'h07);
      n_total++;
      if (bel !== 1'b1) $display("FAIL bel_pulse: got %b required 1", bel);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (bel !== 1'b0) $display("FAIL bel_width: got %b required 0", bel);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      goto_rc(5, 10);
      push_row_fill(5, 10);
      send1(8'h0B);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (we !== 1'b0 || ce !== 1'b0 || bus.o_ready !== 1'b0)
         $display("FAIL reset_abort: got we=%b ce=%b ready=%b required 0 0 0", we, ce, bus.o_ready);
      else n_pass++;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_total++;
      if (bus.o_ready !== 1'b1 || we !== 1'b0 || cur_row !== 5'd0 || cur_col !== 6'd0)
         $display("FAIL reset_idle: got ready=%b we=%b cur=(%0d,%0d) required 1 0 (0,0)",
                  bus.o_ready, we, cur_row, cur_col);
      else n_pass++;
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_char  = 8'h00;
      @(negedge clk);
      test_reset();
      test_char();
      test_goto();
      test_wrap_scroll();
      test_lf_scroll();
      test_ff();
      test_ht();
      test_vt();
      test_back_to_back();
      test_bel();
      test_reset_mid_fill();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
